platform_layer: RTL
===================

# platform_layer

Parametrised platform/tile layer for the VGA pixel pipeline. It overlays up to NUM_SEGS horizontal runs of tiles from a shared tile-sheet ROM onto the incoming `vga_if` stream. Each segment descriptor is written at run time through a config port and double-buffered so that it takes effect only at the next vertical blank. The block sits between the background stage and the sprite stages, where it replaces the fixed-layout map stage.

## Interface
Parameters:
- NUM_SEGS, 4: number of segment descriptors (1..16).
- TILE_W_LOG2, 5: tile width is 2^TILE_W_LOG2 pixels.
- TILE_H_LOG2, 5: tile height is 2^TILE_H_LOG2 lines.
- SHEET_ROW_W, 1: bits selecting the tile-sheet row (1..3).
- ROM_ADDR_W, SHEET_ROW_W+TILE_H_LOG2+TILE_W_LOG2: width of pixel_addr.
- BLANK_RGB, 12'h888: colour driven during hblnk/vblnk.
- KEY_RGB, 12'hF0F: transparent colour key in the ROM.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  layer drawing enable (game running).
- cfg_we  in  1  descriptor write strobe.
- cfg_idx  in  4  descriptor index.
- cfg_data  in  32  descriptor: [10:0] x_start, [21:11] y_start, [27:22] len_tiles (0 = segment disabled), [28+:SHEET_ROW_W] sheet_row.
- cfg_pending  out  1  high while shadow descriptors are not yet committed.
- pixel_addr  out  ROM_ADDR_W  tile-sheet ROM address.
- rgb_pixel  in  12  ROM data; the ROM has 1-cycle synchronous read.
- in  vga_if.in  -  upstream timing and rgb.
- out  vga_if.out  -  downstream timing and rgb.

## Operation
- Descriptors:
  - Shadow bank: written on cfg_we. Writes with cfg_idx ≥ NUM_SEGS are ignored and do not set cfg_pending.
  - Active bank: loaded from the shadow bank on the rising edge of in.vblnk (registered previous value, 0→1).
  - cfg_pending is set by any valid write and cleared on commit.
  - A write in the same cycle as a commit lands in the shadow bank, is excluded from that commit, and leaves cfg_pending = 1.
- Hit test per segment i, using the active bank and the stage-0 in.hcount/in.vcount:
  - len_tiles ≠ 0
  - y_start ≤ vcount ≤ y_start + 2^TILE_H_LOG2 − 1
  - x_start ≤ hcount < x_start + len_tiles·2^TILE_W_LOG2
  - Bounds are computed 12 bits wide, with no wrap-around.
- Priority: when several segments hit, the lowest index wins.
- Address: pixel_addr = {sheet_row, (vcount − y_start)[TILE_H_LOG2−1:0], (hcount − x_start)[TILE_W_LOG2−1:0]}. The horizontal offset wraps per tile, so tiles repeat along the run.
- Output colour, in priority order:
  1. hblnk or vblnk → BLANK_RGB.
  2. enable && hit && rgb_pixel ≠ KEY_RGB → rgb_pixel.
  3. Otherwise → the delayed in.rgb.
- enable is sampled in stage 1. Deasserting it mid-frame takes effect on the next pixel.
- On a miss, pixel_addr holds its previous value.

## Timing
- Pipeline, 3-cycle latency for all timing signals and rgb:
  - Edge 1: hit, selected index and pixel_addr registered; timing and rgb delayed.
  - Edge 2: the ROM presents rgb_pixel; hit and timing delayed again.
  - Edge 3: out.* registered.
- The in→out alignment of hcount, vcount, hsync, vsync, hblnk, vblnk and rgb is exactly 3 cycles.
- Commit happens on the clock edge that samples in.vblnk = 1 after 0. The new descriptors affect pixels entering from the next cycle on.
- Reset (asynchronous, takes effect immediately):
  - All out.* fields = 0, pixel_addr = 0, cfg_pending = 0.
  - Both descriptor banks = 0 (all segments disabled).
  - Pipeline registers = 0, vblnk edge detector = 0.
- Reset asserted mid-frame discards pending writes. After release the output is pass-through until descriptors are written and committed.

## Test plan
- Reset/pass-through: rst pulse, no cfg writes, 1024x768 timing stream → out equals in delayed by 3 cycles, rgb unchanged, cfg_pending = 0.
- Single segment: write idx 0 with x = 64, y = 736, len = 4, row = 0; wait for vblnk; enable = 1.
  - At hcount = 64..191, vcount = 736..767: pixel_addr = {0, v−736, (h−64) mod 32}.
  - out.rgb = ROM data (non-key), 3 cycles later.
  - At hcount = 192: pass-through.
- Double buffering:
  - Write idx 1 mid-frame → cfg_pending = 1 and no visible change this frame.
  - After the vblnk rise: drawn, cfg_pending = 0.
  - A write on the commit cycle keeps cfg_pending = 1.
- Overlap priority: idx 0 (row 0) and idx 2 (row 1) cover the same pixel → address uses row 0. Disable idx 0 (len = 0) and commit → row 1.
- Colour key and blanking:
  - ROM returns 12'hF0F inside a segment → background rgb passes through.
  - During hblnk → 12'h888.
  - enable = 0 → pass-through everywhere.
- Edge cases: write with cfg_idx = NUM_SEGS → ignored, cfg_pending unchanged. Segment with x_start = 1008, len = 2 → drawn only for hcount 1008..1023, no wrap to hcount 0.

Source files
------------

// File: rtl/vga_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank strobes and 12-bit colour.
// Producers use master/out, consumers use slave/in.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/platform_layer.sv
// Platform/tile overlay stage: draws up to NUM_SEGS horizontal tile runs from a
// shared tile-sheet ROM, with descriptors double-buffered and committed at vblank.
module platform_layer #(
  parameter int          NUM_SEGS    = 4,
  parameter int          TILE_W_LOG2 = 5,
  parameter int          TILE_H_LOG2 = 5,
  parameter int          SHEET_ROW_W = 1,
  parameter int          ROM_ADDR_W  = SHEET_ROW_W + TILE_H_LOG2 + TILE_W_LOG2,
  parameter logic [11:0] BLANK_RGB   = 12'h888,
  parameter logic [11:0] KEY_RGB     = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_idx,
  input  logic [31:0]           cfg_data,
  output logic                  cfg_pending,
  output logic [ROM_ADDR_W-1:0] pixel_addr,
  input  logic [11:0]           rgb_pixel,
  vga_if.in                     in,
  vga_if.out                    out
);

  localparam int DESC_W = 28 + SHEET_ROW_W;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  logic [DESC_W-1:0] shadow [NUM_SEGS];
  logic [DESC_W-1:0] active [NUM_SEGS];
  logic              vblnk_prev;
  logic              commit;
  logic              cfg_valid;
  logic              unused_cfg_bits;

  assign commit          = in.vblnk & ~vblnk_prev;
  assign cfg_valid       = cfg_we && ({1'b0, cfg_idx} < 5'(NUM_SEGS));
  assign unused_cfg_bits = ^cfg_data[31:DESC_W];

  // Commit copies the pre-edge shadow contents, so a same-cycle write stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      vblnk_prev  <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      vblnk_prev <= in.vblnk;
      if (commit) begin
        for (int i = 0; i < NUM_SEGS; i++) begin
          active[i] <= shadow[i];
        end
      end
      for (int i = 0; i < NUM_SEGS; i++) begin
        if (cfg_valid && cfg_idx == 4'(i)) begin
          shadow[i] <= cfg_data[DESC_W-1:0];
        end
      end
      if (cfg_valid) begin
        cfg_pending <= 1'b1;
      end else if (commit) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  logic [NUM_SEGS-1:0]   seg_hit;
  logic [ROM_ADDR_W-1:0] seg_addr [NUM_SEGS];
  logic [11:0]           h12;
  logic [11:0]           v12;

  assign h12 = {1'b0, in.hcount};
  assign v12 = {1'b0, in.vcount};

  for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
    logic [11:0]            x_lo;
    logic [11:0]            x_hi;
    logic [11:0]            y_lo;
    logic [11:0]            y_hi;
    logic [5:0]             len;
    logic [TILE_H_LOG2-1:0] v_off;
    logic [TILE_W_LOG2-1:0] h_off;

    assign len  = active[g][27:22];
    assign x_lo = {1'b0, active[g][10:0]};
    assign y_lo = {1'b0, active[g][21:11]};
    assign y_hi = y_lo + 12'((1 << TILE_H_LOG2) - 1);
    assign x_hi = x_lo + ({6'd0, len} << TILE_W_LOG2);

    // Offsets are taken modulo the tile size so tiles repeat along the run.
    assign v_off = v12[TILE_H_LOG2-1:0] - y_lo[TILE_H_LOG2-1:0];
    assign h_off = h12[TILE_W_LOG2-1:0] - x_lo[TILE_W_LOG2-1:0];

    assign seg_hit[g]  = (len != 6'd0) && (v12 >= y_lo) && (v12 <= y_hi) &&
                         (h12 >= x_lo) && (h12 < x_hi);
    assign seg_addr[g] = {active[g][28 +: SHEET_ROW_W], v_off, h_off};
  end

  logic                  hit_any;
  logic [ROM_ADDR_W-1:0] sel_addr;

  // Walking downward lets the lowest-index hitting segment take precedence.
  always_comb begin
    hit_any  = 1'b0;
    sel_addr = '0;
    for (int i = NUM_SEGS - 1; i >= 0; i--) begin
      if (seg_hit[i]) begin
        hit_any  = 1'b1;
        sel_addr = seg_addr[i];
      end
    end
  end

  vga_t        s0;
  vga_t        s1;
  vga_t        s2;
  logic        hit1;
  logic        hit2;
  logic [11:0] rgb_next;

  always_comb begin
    s0.hcount = in.hcount;
    s0.vcount = in.vcount;
    s0.hsync  = in.hsync;
    s0.vsync  = in.vsync;
    s0.hblnk  = in.hblnk;
    s0.vblnk  = in.vblnk;
    s0.rgb    = in.rgb;
  end

  always_comb begin
    if (s2.hblnk || s2.vblnk) begin
      rgb_next = BLANK_RGB;
    end else if (hit2 && rgb_pixel != KEY_RGB) begin
      rgb_next = rgb_pixel;
    end else begin
      rgb_next = s2.rgb;
    end
  end

  // Three-stage pipe: address issue, ROM read, output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      pixel_addr <= '0;
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      s1   <= s0;
      hit1 <= hit_any & enable;
      if (hit_any) begin
        pixel_addr <= sel_addr;
      end
      s2         <= s1;
      hit2       <= hit1;
      out.hcount <= s2.hcount;
      out.vcount <= s2.vcount;
      out.hsync  <= s2.hsync;
      out.vsync  <= s2.vsync;
      out.hblnk  <= s2.hblnk;
      out.vblnk  <= s2.vblnk;
      out.rgb    <= rgb_next;
    end
  end

endmodule
